case_9_mul_share_ctrl: RTL and testbench

Round-robin controller that time-shares one combinational signed multiplier (4-bit × 4-bit → 8-bit) among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the shared multiplier's inputs. It registers the product and returns it on a single tagged response channel. It sits between the kernel's parallel operand producers and the single multiplier instance the schedule allocates.

---
 rtl/case_9_mul_share_ctrl_pkg.sv | 23 ++
 rtl/case_9_rr_pick.sv | 29 ++
 rtl/case_9_mul_share_ctrl.sv | 120 ++++++++++++
 tb/tb_case_9_mul_share_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/case_9_mul_share_ctrl_pkg.sv
// Shared definitions for the multiplier-sharing controller: state codes,
// default sizes and the tag-width helper.
package case_9_mul_share_ctrl_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned DIN_W_DEF  = 4;
  localparam int unsigned DOUT_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t MUL  = 2'd1;
  localparam state_t RESP = 2'd2;

  // Bits needed to index n requesters (minimum 1).
  function automatic int unsigned id_width(input int unsigned n);
    for (int unsigned w = 1; w < 32; w++) begin
      if ((32'd1 << w) >= n) return w;
    end
    return 32;
  endfunction

endpackage

// File: rtl/case_9_rr_pick.sv
// Round-robin pick: first valid requester after last_grant, wrapping modulo NREQ.
module case_9_rr_pick
  import case_9_mul_share_ctrl_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] last_grant,
  output logic [ID_W-1:0] grant,
  output logic            any_valid
);

  // Scan offsets 1..NREQ so last_grant itself has lowest priority.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_grant) + i) % NREQ;
      if (!any_valid && req_valid[idx[ID_W-1:0]]) begin
        any_valid = 1'b1;
        grant     = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/case_9_mul_share_ctrl.sv
// Time-shares one external combinational signed multiplier among NREQ
// requesters. Operands are latched before driving the multiplier; the product
// is registered and returned on a single tagged response channel.
module case_9_mul_share_ctrl
  import case_9_mul_share_ctrl_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned DIN_W  = DIN_W_DEF,
  parameter int unsigned DOUT_W = DOUT_W_DEF,
  parameter int unsigned ID_W   = id_width(NREQ)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIN_W-1:0] req_a,
  input  logic [NREQ*DIN_W-1:0] req_b,
  output logic [DIN_W-1:0]      mul_din0,
  output logic [DIN_W-1:0]      mul_din1,
  input  logic [DOUT_W-1:0]     mul_dout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DOUT_W-1:0]     rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           op_count
);

  state_t            state_q, state_d;
  logic [DIN_W-1:0]  op_a_q, op_b_q;
  logic [ID_W-1:0]   last_grant_q, rsp_id_q;
  logic [DOUT_W-1:0] rsp_data_q;
  logic [15:0]       op_count_q;

  logic [ID_W-1:0]   grant;
  logic              any_valid;
  logic              rsp_done;
  logic              accept;
  logic [DIN_W-1:0]  sel_a, sel_b;

  case_9_rr_pick #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  // Handshake decode: accept only in IDLE, or in RESP while the response drains.
  always_comb begin
    rsp_done  = (state_q == RESP) && rsp_ready;
    accept    = !ap_rst && any_valid && ((state_q == IDLE) || rsp_done);
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant == ID_W'(i)) begin
        sel_a = req_a[i*DIN_W +: DIN_W];
        sel_b = req_b[i*DIN_W +: DIN_W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     state_d = RESP;
      RESP:    if (rsp_done) state_d = accept ? MUL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand, tag and product registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (accept) begin
        op_a_q       <= sel_a;
        op_b_q       <= sel_b;
        last_grant_q <= grant;
        rsp_id_q     <= grant;
      end
      if (state_q == MUL) rsp_data_q <= mul_dout;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)        op_count_q <= '0;
    else if (rsp_done) op_count_q <= op_count_q + 16'd1;
  end

  // Multiplier only ever sees latched operands.
  assign mul_din0  = op_a_q;
  assign mul_din1  = op_b_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_case_9_mul_share_ctrl.sv
// Directed bench for case_9_mul_share_ctrl with a behavioural 4x4 signed
// multiplier standing in for the external shared instance.
module tb_case_9_mul_share_ctrl;

  localparam int NREQ   = 4;
  localparam int DIN_W  = 4;
  localparam int DOUT_W = 8;
  localparam int ID_W   = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*DIN_W-1:0] req_a;
  logic [NREQ*DIN_W-1:0] req_b;
  logic [DIN_W-1:0]      mul_din0;
  logic [DIN_W-1:0]      mul_din1;
  logic [DOUT_W-1:0]     mul_dout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DOUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           op_count;

  int vectors     = 0;
  int miscompares = 0;

  case_9_mul_share_ctrl #(
    .NREQ   (NREQ),
    .DIN_W  (DIN_W),
    .DOUT_W (DOUT_W),
    .ID_W   (ID_W)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .op_count  (op_count)
  );

  // External multiplier: sign-extend to 8 bits, low 8 bits of product.
  logic signed [7:0] ext0, ext1;
  assign ext0     = $signed(mul_din0);
  assign ext1     = $signed(mul_din1);
  assign mul_dout = ext0 * ext1;

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
    req_a[id*DIN_W +: DIN_W] = a;
    req_b[id*DIN_W +: DIN_W] = b;
  endtask

  // One isolated transaction from IDLE with rsp_ready held high.
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp_p, input string tag);
    @(negedge ap_clk);
    set_ops(id, a, b);
    req_valid = 4'(1 << id);
    #1;
    check_eq({tag, ".ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check_eq({tag, ".din0"}, 32'(mul_din0), 32'(a));
    check_eq({tag, ".din1"}, 32'(mul_din1), 32'(b));
    check_eq({tag, ".mulvalid"}, 32'(rsp_valid), 32'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, ".data"}, 32'(rsp_data), 32'(exp_p));
    check_eq({tag, ".id"}, 32'(rsp_id), 32'(id));
    @(posedge ap_clk);
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = 4'hf;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with all requesters valid to show req_ready is gated.
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq("rst.ready", 32'(req_ready), 32'd0);
    check_eq("rst.valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.data", 32'(rsp_data), 32'd0);
    check_eq("rst.id", 32'(rsp_id), 32'd0);
    check_eq("rst.din0", 32'(mul_din0), 32'd0);
    check_eq("rst.din1", 32'(mul_din1), 32'd0);
    check_eq("rst.count", 32'(op_count), 32'd0);
    req_valid = '0;
    ap_rst    = 1'b0;

    // Single request, -8 * -8 = +64.
    run_one(2, 4'h8, 4'h8, 8'h40, "single");
    @(negedge ap_clk);
    check_eq("single.count", 32'(op_count), 32'd1);
    check_eq("single.idle", 32'(rsp_valid), 32'd0);

    // Sign corners.
    run_one(0, 4'h7, 4'h8, 8'hc8, "c_7xm8");
    run_one(1, 4'hf, 4'hf, 8'h01, "c_m1xm1");
    run_one(3, 4'h7, 4'h7, 8'h31, "c_7x7");
    run_one(0, 4'h0, 4'h8, 8'h00, "c_0xm8");
    @(negedge ap_clk);
    check_eq("corner.count", 32'(op_count), 32'd5);

    // Backpressure: 5 * (-3) = -15 held for 5 cycles.
    set_ops(1, 4'h5, 4'hd);
    req_valid = 4'b0010;
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge ap_clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge ap_clk);
      req_valid = 4'hf;
      #1;
      check_eq("bp.valid", 32'(rsp_valid), 32'd1);
      check_eq("bp.data", 32'(rsp_data), 32'hf1);
      check_eq("bp.id", 32'(rsp_id), 32'd1);
      check_eq("bp.ready", 32'(req_ready), 32'd0);
      check_eq("bp.count", 32'(op_count), 32'd5);
      @(posedge ap_clk);
    end
    @(negedge ap_clk);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq("bp.count_after", 32'(op_count), 32'd6);
    check_eq("bp.idle", 32'(rsp_valid), 32'd0);

    // Reset while in MUL.
    set_ops(2, 4'h3, 4'h3);
    req_valid = 4'b0100;
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check_eq("rstmid.pre_din0", 32'(mul_din0), 32'd3);
    ap_rst    = 1'b1;
    req_valid = 4'hf;
    for (int i = 0; i < NREQ; i++) set_ops(i, 4'(i + 1), 4'h3);
    #1;
    check_eq("rstmid.valid", 32'(rsp_valid), 32'd0);
    check_eq("rstmid.data", 32'(rsp_data), 32'd0);
    check_eq("rstmid.id", 32'(rsp_id), 32'd0);
    check_eq("rstmid.din0", 32'(mul_din0), 32'd0);
    check_eq("rstmid.din1", 32'(mul_din1), 32'd0);
    check_eq("rstmid.count", 32'(op_count), 32'd0);
    check_eq("rstmid.ready", 32'(req_ready), 32'd0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq("rstmid.hold_valid", 32'(rsp_valid), 32'd0);
    check_eq("rstmid.hold_ready", 32'(req_ready), 32'd0);
    ap_rst = 1'b0;
    #1;
    check_eq("rstmid.first_grant", 32'(req_ready), 32'b0001);

    // All four valid, back-to-back: grants 0,1,2,3,0,... products 3*(i+1).
    for (int k = 0; k < 8; k++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      check_eq("rr.mul_valid", 32'(rsp_valid), 32'd0);
      check_eq("rr.din0", 32'(mul_din0), 32'((k % 4) + 1));
      @(posedge ap_clk);
      @(negedge ap_clk);
      check_eq("rr.valid", 32'(rsp_valid), 32'd1);
      check_eq("rr.id", 32'(rsp_id), 32'(k % 4));
      check_eq("rr.data", 32'(rsp_data), 32'(3 * ((k % 4) + 1)));
      check_eq("rr.next_grant", 32'(req_ready), 32'(1 << ((k + 1) % 4)));
    end
    req_valid = '0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    check_eq("rr.count", 32'(op_count), 32'd8);
    check_eq("rr.idle", 32'(rsp_valid), 32'd0);

    // Counter wrap from a preloaded value.
    force dut.op_count_q = 16'hfffe;
    #1;
    release dut.op_count_q;
    #1;
    check_eq("wrap.preload", 32'(op_count), 32'hfffe);
    run_one(3, 4'h9, 4'h2, 8'hf2, "wrap1");
    @(negedge ap_clk);
    check_eq("wrap.ffff", 32'(op_count), 32'hffff);
    run_one(1, 4'h4, 4'h4, 8'h10, "wrap2");
    @(negedge ap_clk);
    check_eq("wrap.zero", 32'(op_count), 32'h0000);
    check_eq("wrap.idle", 32'(rsp_valid), 32'd0);
    run_one(0, 4'he, 4'h5, 8'hf6, "wrap3");
    @(negedge ap_clk);
    check_eq("wrap.one", 32'(op_count), 32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
